// File: rtl/rv_muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide unit.
package rv_muldiv_pkg;

  localparam int unsigned MULDIV_XLEN = 32;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'd0,
    MULDIV_MULH   = 3'd1,
    MULDIV_MULHSU = 3'd2,
    MULDIV_MULHU  = 3'd3,
    MULDIV_DIV    = 3'd4,
    MULDIV_DIVU   = 3'd5,
    MULDIV_REM    = 3'd6,
    MULDIV_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic op_a_signed(input muldiv_op_e op);
    return op inside {MULDIV_MUL, MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return op inside {MULDIV_MUL, MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared 64-bit accumulator: one shift-add (multiply) or restoring
// shift-subtract (divide) iteration per step_i.
module muldiv_iter_core
  import rv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_mode_i,
  input  logic [XLEN-1:0]   opa_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_shift;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_diff;

  // Multiply: {hi, lo} with multiplier in lo; divide: {remainder, dividend/quotient}.
  always_comb begin
    acc_d     = acc_q;
    opb_d     = opb_q;
    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    rem_ge    = rem_shift >= {1'b0, opb_q};
    rem_diff  = rem_shift[XLEN-1:0] - opb_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, opa_i};
      opb_d = opb_i;
    end else if (step_i) begin
      if (div_mode_i) begin
        if (rem_ge) begin
          acc_d = {rem_diff, acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end
      end else if (acc_q[0]) begin
        acc_d = {add_sum, acc_q[XLEN-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, handshake, divide special
// cases and final sign correction around muldiv_iter_core.
module muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              a_neg_q, a_neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_e        op_in;
  logic              a_neg_in, b_neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic              core_load, core_step;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fixed_res;

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (core_load),
    .step_i    (core_step),
    .div_mode_i(op_q[2]),
    .opa_i     (mag_a),
    .opb_i     (mag_b),
    .acc_o     (acc)
  );

  always_comb begin
    op_in       = muldiv_op_e'(op_i);
    a_neg_in    = op_a_signed(op_in) & rs1_data_i[XLEN-1];
    b_neg_in    = op_b_signed(op_in) & rs2_data_i[XLEN-1];
    mag_a       = a_neg_in ? -rs1_data_i : rs1_data_i;
    mag_b       = b_neg_in ? -rs2_data_i : rs2_data_i;
    div_zero    = (rs2_data_i == '0);
    div_ovf     = (op_in == MULDIV_DIV || op_in == MULDIV_REM) &&
                  (rs1_data_i == INT_MIN) && (rs2_data_i == '1);
    // op_i[1] distinguishes REM/REMU from DIV/DIVU.
    if (div_zero) begin
      special_res = op_i[1] ? rs1_data_i : DIV_BY_ZERO_Q;
    end else begin
      special_res = op_i[1] ? '0 : INT_MIN;
    end

    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = a_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fixed_res = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q == MULDIV_MUL) begin
      fixed_res = prod_fix[XLEN-1:0];
    end else begin
      fixed_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    a_neg_d   = a_neg_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          op_d    = op_in;
          rd_d    = rd_i;
          neg_d   = a_neg_in ^ b_neg_in;
          a_neg_d = a_neg_in;
          cnt_d   = '0;
          if (op_i[2] && (div_zero || div_ovf)) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else begin
            core_load = 1'b1;
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        core_step = !flush_i;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == '1) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = fixed_res;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (result_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= MULDIV_MUL;
      rd_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      result_q <= result_d;
    end
  end

  assign ready_o        = (state_q == ST_IDLE);
  assign result_valid_o = (state_q == ST_DONE);
  assign result_o       = result_q;
  assign rd_o           = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, handshake
// corner cases and a randomized sweep against a 64-bit arithmetic model.
module tb_muldiv_unit;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t scb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  muldiv_unit #(
    .XLEN(32)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .op_i          (op_i),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .rd_i          (rd_i),
    .flush_i       (flush_i),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_o      (result_o),
    .rd_o          (rd_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sbv, p;
    longint unsigned ua, ub, up;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    p   = 0;
    up  = 0;
    case (op)
      3'd0: p = sa * sbv;
      3'd1: p = (sa * sbv) >>> 32;
      3'd2: p = (sa * longint'(ub)) >>> 32;
      3'd3: begin up = (ua * ub) >> 32; p = longint'(up); end
      3'd4: p = (b == 32'd0) ? -1 : sa / sbv;
      3'd5: p = (b == 32'd0) ? -1 : longint'(ua / ub);
      3'd6: p = (b == 32'd0) ? longint'(ua) : sa % sbv;
      default: p = (b == 32'd0) ? longint'(ua) : longint'(ua % ub);
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && (b == 32'd0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called just after a falling edge; the request is captured at the next rising edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    exp_t e;
    int   cyc;
    e.res = exp_res;
    e.rd  = rd;
    scb.push_back(e);
    op_i           = op;
    rs1_data_i     = a;
    rs2_data_i     = b;
    rd_i           = rd;
    valid_i        = 1'b1;
    result_ready_i = 1'b1;
    @(negedge clk_i);
    cyc     = 1;
    valid_i = 1'b0;
    check({tag, "_busy"}, 32'(ready_o), 32'd0);
    while (!result_valid_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    e = scb.pop_front();
    check({tag, "_res"}, result_o, e.res);
    check({tag, "_rd"}, 32'(rd_o), 32'(e.rd));
    @(negedge clk_i);
    check({tag, "_idle"}, {30'd0, ready_o, result_valid_o}, 32'd2);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int hi;
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (result_valid_o) hi++;
    end
    check(tag, 32'(hi), 32'd0);
  endtask

  initial begin
    int          cyc;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    int          sel;

    rst_i          = 1'b1;
    valid_i        = 1'b0;
    op_i           = '0;
    rs1_data_i     = '0;
    rs2_data_i     = '0;
    rd_i           = '0;
    flush_i        = 1'b0;
    result_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(result_valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", 32'(rd_o), 32'd0);

    run_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 34);
    run_op("mulh_min",  3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, 34);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 34);
    run_op("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF, 34);
    run_op("div_neg",   3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD, 34);
    run_op("rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 34);
    run_op("divu",      3'd5, 32'd100,        32'd7,         5'd7,  32'd14,        34);
    run_op("remu",      3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         34);
    run_op("divu_z",    3'd5, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1);
    run_op("remu_z",    3'd7, 32'd5,          32'd0,         5'd10, 32'd5,         1);
    run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1);
    run_op("rd_zero",   3'd0, 32'd6,          32'd7,         5'd0,  32'd42,        34);

    // Backpressure: result held while writeback stalls; requests in that window are dropped.
    op_i = 3'd5; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_i = 5'd13;
    valid_i = 1'b1; result_ready_i = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b0;
    cyc = 1;
    while (!result_valid_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check("bp_lat", 32'(cyc), 32'd34);
    for (int i = 0; i < 5; i++) begin
      valid_i = (i % 2 == 0);
      op_i = 3'd0; rs1_data_i = 32'd9; rs2_data_i = 32'd9; rd_i = 5'd20;
      @(negedge clk_i);
      check("bp_res", result_o, 32'd14);
      check("bp_rd", 32'(rd_o), 32'd13);
      check("bp_valid", {30'd0, ready_o, result_valid_o}, 32'd1);
    end
    valid_i = 1'b0;
    result_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_release", {30'd0, ready_o, result_valid_o}, 32'd2);
    watch_quiet("bp_no_queue", 40);

    // Flush during CALC iteration 10.
    op_i = 3'd0; rs1_data_i = 32'd123; rs2_data_i = 32'd456; rd_i = 5'd14;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_calc", {30'd0, ready_o, result_valid_o}, 32'd2);
    watch_quiet("flush_calc_quiet", 40);

    // Flush together with valid_i must not accept.
    op_i = 3'd5; rs1_data_i = 32'd9; rs2_data_i = 32'd0; rd_i = 5'd15;
    valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_accept", 32'(ready_o), 32'd1);
    watch_quiet("flush_accept_quiet", 40);

    // Flush in DONE alongside result_ready_i.
    op_i = 3'd5; rs1_data_i = 32'd9; rs2_data_i = 32'd0; rd_i = 5'd16;
    valid_i = 1'b1; result_ready_i = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b0;
    check("flush_done_pre", 32'(result_valid_o), 32'd1);
    flush_i = 1'b1; result_ready_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_done", {30'd0, ready_o, result_valid_o}, 32'd2);

    // Asynchronous reset mid-CALC.
    op_i = 3'd0; rs1_data_i = 32'd77; rs2_data_i = 32'd88; rd_i = 5'd17;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (14) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("arst_ready", 32'(ready_o), 32'd1);
    check("arst_valid", 32'(result_valid_o), 32'd0);
    check("arst_result", result_o, 32'd0);
    check("arst_rd", 32'(rd_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    run_op("post_rst", 3'd0, 32'd3, 32'd4, 5'd18, 32'd12, 34);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      rrd = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      run_op("rand", rop, ra, rb, rrd, ref_res(rop, ra, rb), ref_lat(rop, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: it consumes the two read-port operands plus the destination index, and feeds its result and tag back to the register-file write port through writeback.
- It is a multi-cycle, valid/ready-handshaked unit. It holds one operation at a time.

Parameters:
- XLEN, 32: operand and result width. Only 32 is supported; the parameter is for readability only.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request; high only in IDLE.
- op_i  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data_i  in  32  operand A, from register-file read port 1.
- rs2_data_i  in  32  operand B, from register-file read port 2.
- rd_i  in  5  destination register tag.
- flush_i  in  1  abort any in-flight operation.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  writeback accepts the result.
- result_o  out  32  result.
- rd_o  out  5  destination tag of the result.

Behaviour:
- Reset values: ready_o=1, result_valid_o=0, result_o=0, rd_o=0. The FSM is in IDLE and all datapath registers are 0.
- Reset asserted mid-operation drops the operation immediately.
- Acceptance happens at an edge where valid_i & ready_o & !flush_i. At that edge op, operands and rd are captured.
- Operands are not sampled in any other cycle. valid_i while ready_o=0 is ignored and does not queue.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on a normal accept.
  - IDLE -> DONE on a special-case divide.
  - CALC runs exactly 32 cycles (5-bit counter, 0..31), then -> FIX.
  - FIX (one cycle, sign correction and result select) -> DONE.
  - DONE -> IDLE at the edge where result_ready_i=1.
- Latency, with accept at edge T:
  - Normal operation: result_valid_o rises after edge T+34.
  - Special case: result_valid_o rises after edge T+1.
- The next request can be accepted one cycle after the result handshake.
- In DONE, result_o and rd_o are held stable while result_ready_i=0. result_valid_o never drops without a handshake, flush or reset.
- Multiply:
  - Take the magnitude of each operand that is treated as signed: MUL/MULH both signed, MULHSU rs1 only, MULHU neither.
  - Form the 64-bit unsigned product by 32 shift-add iterations.
  - In FIX, negate the 64-bit product if the operand signs differ.
  - MUL returns product[31:0]; the others return product[63:32].
- Divide:
  - DIV/REM take magnitudes of both operands; DIVU/REMU are unsigned.
  - 32 restoring iterations produce quotient and remainder.
  - In FIX, negate the quotient if the signs differ, and give the remainder the sign of the dividend.
- Special cases are detected at accept and bypass CALC/FIX:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
- flush_i: any state returns to IDLE at the next edge. result_valid_o=0 after that edge, and the result is discarded.
  - Flush in the same cycle as valid_i: no accept.
  - Flush in DONE together with result_ready_i: flush wins; writeback must ignore that cycle.
- rd_i = 0 is executed normally. Suppressing the write is the register file's job.

Decomposition:
- Package rv_muldiv_pkg holds:
  - the op encodings (MULDIV_MUL ... MULDIV_REMU, 3 bits);
  - the FSM state encoding (2 bits);
  - constants DIV_BY_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- One sub-module is natural: muldiv_iter_core. It holds the shared 64-bit accumulator and the shift/add or shift/subtract step, and performs one iteration per enable.
- The top level holds the FSM, handshake, special-case detection and sign fix.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), accepted at T -> result_o=0xFFFFFFEB, result_valid_o first high after edge T+34, ready_o low from T+1 until after the handshake.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each valid after edge T+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Backpressure: result_ready_i held 0 for 5 cycles with rd_i=13 -> result_o and rd_o=13 stable, and valid_i pulses in that window are not accepted.
- Flush at CALC iteration 10 -> ready_o=1 next cycle and no result_valid_o. rst_i pulsed mid-CALC -> outputs at reset values immediately (asynchronous), then a fresh MUL 3 x 4 -> 12.
